// File: rtl/transpad_seq_cu_pkg.sv
// Shared definitions for the TransPad sequencing control unit.
package transpad_seq_cu_pkg;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_CONFIG   = 3'd1,
        S_INIT_OFS = 3'd2,
        S_LOAD_TX  = 3'd3,
        S_TRANSL   = 3'd4,
        S_UPD_OFS  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Idle states are the only ones that ignore hold and report busy=0.
    function automatic logic is_idle(input state_t s);
        return (s == S_RESET) || (s == S_CONFIG);
    endfunction

endpackage

// File: rtl/transpad_bcnt.sv
// Bounded up-counter: counts on en, wraps to zero after reaching bound.
module transpad_bcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] bound,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == bound);

    // Count register; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/transpad_seq_cu.sv
// TransPad control unit: config, offset init/update, interleaved TX-address
// loading and translation over an inner/outer loop with hold, abort,
// continuous mode and done/error reporting.
module transpad_seq_cu
    import transpad_seq_cu_pkg::*;
#(
    parameter int INTLV_W = 3,
    parameter int LOOP_W  = 16,
    parameter int OLOOP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_req,
    output logic               start_ack,
    input  logic               stop_req,
    input  logic               hold,
    input  logic               cont_mode,
    input  logic [INTLV_W-1:0] cfg_intlv,
    input  logic [LOOP_W-1:0]  cfg_loop,
    input  logic [OLOOP_W-1:0] cfg_oloop,
    output logic               regs_clr,
    output logic               conf_dec_en,
    output logic               lst_addr_reg_we,
    output logic               ofs_addr_reg_we,
    output logic               ofs_addr_sel,
    output logic               tx_addr_dec_en,
    output logic               tx_addr_sel,
    output logic               act,
    output logic [INTLV_W-1:0] intlv_idx,
    output logic [LOOP_W-1:0]  loop_idx,
    output logic [OLOOP_W-1:0] oloop_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err
);

    state_t             state;
    state_t             state_nxt;
    logic [INTLV_W-1:0] intlv_bnd;
    logic [LOOP_W-1:0]  loop_bnd;
    logic [OLOOP_W-1:0] oloop_bnd;
    logic               cfg_ok;
    logic               accept;
    logic               stop_now;
    logic               cnt_clr;
    logic               intlv_en;
    logic               loop_en;
    logic               oloop_en;
    logic               intlv_last;
    logic               loop_last;
    logic               oloop_last;

    assign cfg_ok   = (cfg_loop != '0) && (cfg_oloop != '0);
    assign accept   = (state == S_CONFIG) && start_req && cfg_ok;
    assign stop_now = (state == S_TRANSL) && !hold && stop_req;

    // Counters are cleared while idle and on the (non-held) exit from S_DONE.
    assign cnt_clr  = is_idle(state) || ((state == S_DONE) && !hold);
    assign intlv_en = (state == S_LOAD_TX) && !hold;
    assign loop_en  = (state == S_TRANSL) && !hold && !stop_req;
    assign oloop_en = loop_en && loop_last;

    transpad_bcnt #(.W(INTLV_W)) u_intlv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (intlv_en),
        .bound (intlv_bnd),
        .count (intlv_idx),
        .last  (intlv_last)
    );

    transpad_bcnt #(.W(LOOP_W)) u_loop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (loop_en),
        .bound (loop_bnd),
        .count (loop_idx),
        .last  (loop_last)
    );

    transpad_bcnt #(.W(OLOOP_W)) u_oloop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (oloop_en),
        .bound (oloop_bnd),
        .count (oloop_idx),
        .last  (oloop_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Bound latch on accepted start; loop bounds kept as count-minus-one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intlv_bnd <= '0;
            loop_bnd  <= '0;
            oloop_bnd <= '0;
        end else if (accept) begin
            intlv_bnd <= cfg_intlv;
            loop_bnd  <= cfg_loop - LOOP_W'(1);
            oloop_bnd <= cfg_oloop - OLOOP_W'(1);
        end
    end

    // Abort flag: set by an honoured stop, held until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else if (accept) begin
            aborted <= 1'b0;
        end else if (stop_now) begin
            aborted <= 1'b1;
        end
    end

    // Next-state and output decode; hold freezes non-idle states.
    always_comb begin
        state_nxt       = state;
        regs_clr        = 1'b0;
        conf_dec_en     = 1'b0;
        lst_addr_reg_we = 1'b0;
        ofs_addr_reg_we = 1'b0;
        ofs_addr_sel    = 1'b0;
        tx_addr_dec_en  = 1'b0;
        tx_addr_sel     = 1'b0;
        act             = 1'b0;
        done            = 1'b0;
        busy            = !is_idle(state);
        start_ack       = accept;
        cfg_err         = (state == S_CONFIG) && start_req && !cfg_ok;
        case (state)
            S_RESET: begin
                regs_clr  = 1'b1;
                state_nxt = S_CONFIG;
            end
            S_CONFIG: begin
                conf_dec_en     = 1'b1;
                lst_addr_reg_we = 1'b1;
                if (accept) begin
                    state_nxt = S_INIT_OFS;
                end
            end
            S_INIT_OFS: begin
                if (!hold) begin
                    ofs_addr_reg_we = 1'b1;
                    state_nxt       = S_LOAD_TX;
                end
            end
            S_LOAD_TX: begin
                if (!hold) begin
                    tx_addr_dec_en = 1'b1;
                    if (intlv_last) begin
                        state_nxt = S_TRANSL;
                    end
                end
            end
            S_TRANSL: begin
                tx_addr_sel = 1'b1;
                if (!hold) begin
                    act = 1'b1;
                    if (stop_req) begin
                        state_nxt = S_DONE;
                    end else if (loop_last) begin
                        state_nxt = oloop_last ? S_DONE : S_UPD_OFS;
                    end
                end
            end
            S_UPD_OFS: begin
                ofs_addr_sel = 1'b1;
                if (!hold) begin
                    ofs_addr_reg_we = 1'b1;
                    state_nxt       = S_LOAD_TX;
                end
            end
            S_DONE: begin
                if (!hold) begin
                    done      = 1'b1;
                    state_nxt = (cont_mode && !aborted) ? S_INIT_OFS : S_CONFIG;
                end
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_transpad_seq_cu.sv
// Scoreboard bench for transpad_seq_cu: a reference model expands each run
// into its expected strobe events; a monitor compares observed strobes.
module tb_transpad_seq_cu;

    localparam int IW = 3;
    localparam int LW = 16;
    localparam int OW = 16;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_INIT = 2;
    localparam int K_UPD  = 3;
    localparam int K_LOAD = 4;
    localparam int K_ACT  = 5;
    localparam int K_DONE = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_req = 1'b0;
    logic          stop_req = 1'b0;
    logic          hold = 1'b0;
    logic          cont_mode = 1'b0;
    logic [IW-1:0] cfg_intlv = '0;
    logic [LW-1:0] cfg_loop = '0;
    logic [OW-1:0] cfg_oloop = '0;
    logic          start_ack, regs_clr, conf_dec_en, lst_addr_reg_we;
    logic          ofs_addr_reg_we, ofs_addr_sel, tx_addr_dec_en, tx_addr_sel;
    logic          act, busy, done, aborted, cfg_err;
    logic [IW-1:0] intlv_idx;
    logic [LW-1:0] loop_idx;
    logic [OW-1:0] oloop_idx;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  done_cyc[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  ack_cnt = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    bit  stall_en = 1'b0;

    transpad_seq_cu #(.INTLV_W(IW), .LOOP_W(LW), .OLOOP_W(OW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_req       (start_req),
        .start_ack       (start_ack),
        .stop_req        (stop_req),
        .hold            (hold),
        .cont_mode       (cont_mode),
        .cfg_intlv       (cfg_intlv),
        .cfg_loop        (cfg_loop),
        .cfg_oloop       (cfg_oloop),
        .regs_clr        (regs_clr),
        .conf_dec_en     (conf_dec_en),
        .lst_addr_reg_we (lst_addr_reg_we),
        .ofs_addr_reg_we (ofs_addr_reg_we),
        .ofs_addr_sel    (ofs_addr_sel),
        .tx_addr_dec_en  (tx_addr_dec_en),
        .tx_addr_sel     (tx_addr_sel),
        .act             (act),
        .intlv_idx       (intlv_idx),
        .loop_idx        (loop_idx),
        .oloop_idx       (oloop_idx),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            K_ACK:   return "ACK";
            K_ERR:   return "ERR";
            K_INIT:  return "INIT";
            K_UPD:   return "UPD";
            K_LOAD:  return "LOAD";
            K_ACT:   return "ACT";
            K_DONE:  return "DONE";
            default: return "?";
        endcase
    endfunction

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic push(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int a, input int b);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event at cycle %0d: got %s(%0d,%0d) expected nothing",
                     cyc, kname(k), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                n_err++;
                $display("FAIL event at cycle %0d: got %s(%0d,%0d) expected %s(%0d,%0d)",
                         cyc, kname(k), a, b, kname(e.kind), e.a, e.b);
            end
        end
    endtask

    // Reference model: expected strobe sequence for a run.
    // k = global index of the translation cycle carrying stop_req (-1: none).
    task automatic push_run(input int ni, input int nl, input int no, input int k,
                            input bit with_ack, input int reps);
        if (with_ack) push(K_ACK, 0, 0);
        for (int r = 0; r < reps; r++) begin
            bit ab = 1'b0;
            push(K_INIT, 0, 0);
            for (int p = 0; p < no && !ab; p++) begin
                for (int i = 0; i <= ni; i++) push(K_LOAD, i, p);
                for (int l = 0; l < nl && !ab; l++) begin
                    push(K_ACT, l, p);
                    if (p * nl + l == k) ab = 1'b1;
                end
                if (!ab && p < no - 1) push(K_UPD, p + 1, 0);
            end
            push(K_DONE, int'(ab), 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (stall_en) begin
            hold     = ($urandom_range(0, 2) == 0);
            stop_req = hold && ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic start_run(input int ni, input int nl, input int no);
        int a0;
        int n;
        step();
        cfg_intlv = IW'(ni);
        cfg_loop  = LW'(nl);
        cfg_oloop = OW'(no);
        a0 = ack_cnt;
        n = 0;
        start_req = 1'b1;
        while (ack_cnt == a0 && n < 50) begin
            step();
            n++;
        end
        start_req = 1'b0;
        if (ack_cnt == a0) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout: got no start_ack expected one within 50 cycles");
        end
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            step();
            n++;
        end
        if (done_cnt < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
        end
    endtask

    task automatic run(input int ni, input int nl, input int no, input int k, input bit stall);
        int d0;
        int p;
        int l;
        int t;
        d0 = done_cnt;
        push_run(ni, nl, no, k, 1'b1, 1);
        stall_en = stall;
        start_run(ni, nl, no);
        if (k >= 0) begin
            p = k / nl;
            l = k % nl;
            t = 1 + p * (ni + nl + 2) + (ni + 1) + l;
            repeat (t) step();
            stop_req = 1'b1;
            step();
            stop_req = 1'b0;
        end
        wait_done(d0 + 1);
        stall_en = 1'b0;
        hold = 1'b0;
        stop_req = 1'b0;
    endtask

    initial begin
        int base;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst) begin
                    if (start_ack) begin
                        ack_cnt++;
                        observe(K_ACK, 0, 0);
                    end
                    if (cfg_err) observe(K_ERR, int'(busy), 0);
                    if (ofs_addr_reg_we && !ofs_addr_sel) observe(K_INIT, int'(oloop_idx), int'(aborted));
                    if (ofs_addr_reg_we && ofs_addr_sel) observe(K_UPD, int'(oloop_idx), 0);
                    if (tx_addr_dec_en) observe(K_LOAD, int'(intlv_idx), int'(oloop_idx));
                    if (act) observe(K_ACT, int'(loop_idx), int'(oloop_idx));
                    if (done) begin
                        done_cnt++;
                        done_cyc.push_back(cyc);
                        observe(K_DONE, int'(aborted), 0);
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_regs_clr", int'(regs_clr), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(intlv_idx) + int'(loop_idx) + int'(oloop_idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_conf_dec_en", int'(conf_dec_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Basic pass structure.
        run(1, 3, 2, -1, 1'b0);
        check("basic_aborted", int'(aborted), 0);
        check("basic_conf_dec_en", int'(conf_dec_en), 1);

        // Illegal bounds.
        step();
        cfg_loop = '0;
        cfg_oloop = OW'(2);
        push(K_ERR, 0, 0);
        start_req = 1'b1;
        step();
        cfg_loop = LW'(3);
        cfg_oloop = '0;
        push(K_ERR, 0, 0);
        step();
        start_req = 1'b0;
        step();
        check("illegal_busy", int'(busy), 0);

        // Abort on 2nd translation of the first pass, then on the very last one.
        run(1, 3, 2, 1, 1'b0);
        check("abort_flag_kept", int'(aborted), 1);
        check("abort_busy", int'(busy), 0);
        cont_mode = 1'b1;
        run(1, 3, 2, 5, 1'b0);
        cont_mode = 1'b0;
        check("abort_last_flag", int'(aborted), 1);

        // Hold four cycles in the middle of translation.
        push_run(1, 3, 1, -1, 1'b1, 1);
        base = done_cnt;
        start_run(1, 3, 1);
        repeat (4) step();
        hold = 1'b1;
        @(negedge clk);
        check("hold_act", int'(act), 0);
        check("hold_loop_idx", int'(loop_idx), 1);
        check("hold_busy", int'(busy), 1);
        repeat (3) step();
        @(negedge clk);
        check("hold_loop_idx_late", int'(loop_idx), 1);
        step();
        hold = 1'b0;
        wait_done(base + 1);

        // Continuous mode: three back-to-back runs from one start.
        push_run(0, 2, 1, -1, 1'b1, 3);
        cont_mode = 1'b1;
        base = done_cnt;
        start_run(0, 2, 1);
        wait_done(base + 2);
        cont_mode = 1'b0;
        wait_done(base + 3);
        if (done_cyc.size() >= base + 3) begin
            check("cont_period_1", done_cyc[base + 1] - done_cyc[base], 5);
            check("cont_period_2", done_cyc[base + 2] - done_cyc[base + 1], 5);
        end
        check("cont_back_to_config", int'(busy), 0);

        // Boundary: maximum interleave, single translation, single pass.
        run(7, 1, 1, -1, 1'b0);
        run(7, 1, 1, 0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            int ni;
            int nl;
            int no;
            int mode;
            ni = int'($urandom_range(0, 7));
            nl = int'($urandom_range(1, 5));
            no = int'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            if (mode == 2) begin
                run(ni, nl, no, int'($urandom_range(0, nl * no - 1)), 1'b0);
            end else begin
                run(ni, nl, no, -1, mode == 1);
            end
        end

        // Reset during the first TX-address load.
        push(K_ACK, 0, 0);
        push(K_INIT, 0, 0);
        start_run(2, 2, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_regs_clr", int'(regs_clr), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_idx", int'(intlv_idx) + int'(loop_idx) + int'(oloop_idx), 0);
        check("midrst_load_en", int'(tx_addr_dec_en), 0);
        check("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_still_reset", int'(regs_clr), 1);
        @(negedge clk);
        check("midrst_config", int'(conf_dec_en), 1);
        check("midrst_regs_clr_off", int'(regs_clr), 0);
        repeat (3) step();

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
